// File: rtl/even_parity_frame_receiver.sv
// Serial receiver for start + 4 data bits (LSB first) + even parity + stop frames.
// Mid-bit sampling from the detected start edge; results are published with a one-cycle valid pulse.
module even_parity_frame_receiver #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       bit_idx;
  logic [3:0]       shreg;
  logic             par_bit;

  assign fsm_state = state;

  // cnt counts edges since the last sample point; it restarts at the start edge and at each sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx;
            bit_idx        <= bit_idx + 2'd1;
            if (bit_idx == 2'd3) state <= PARITY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx;
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // A bad stop bit still publishes the frame, flagged through frame_err.
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            valid      <= 1'b1;
            data       <= shreg;
            parity_err <= ^{shreg, par_bit};
            frame_err  <= ~rx;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/even_parity_frame_receiver.md
EVEN_PARITY_FRAME_RECEIVER -- requirements
Module: even_parity_frame_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit period; SHALL be even and >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rx  input  1  serial line, idle high, synchronous to clk; carries frames from the even-parity generator stage.
REQ-005 data  output  4  received data bits; bit 0 = first data bit on the line (generator input a), bit 3 = last (input d).
REQ-006 valid  output  1  one-cycle pulse marking a completed frame; data and error flags are valid in that cycle.
REQ-007 parity_err  output  1  high when the received data plus parity bit contain an odd number of ones.
REQ-008 frame_err  output  1  high when the stop bit sampled low.
REQ-009 busy  output  1  high whenever the FSM is outside IDLE.

Function
REQ-010 Frame format SHALL be: start (0), data bit 0..3 LSB first, even parity bit, stop (1); 7 bit periods total.
REQ-011 The FSM SHALL have exactly five states: IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE -> START when rx is sampled 0; call that edge t0; the bit counter and cycle counter SHALL clear at t0.
REQ-013 In START, rx SHALL be resampled at t0 + CLKS_PER_BIT/2 (mid-bit); if 1 -> IDLE (false start, no valid, no flags); if 0 -> DATA.
REQ-014 Data bit k (k = 0..3) SHALL be sampled at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT into data[k]; after k = 3 -> PARITY.
REQ-015 Parity bit SHALL be sampled at t0 + CLKS_PER_BIT/2 + 5*CLKS_PER_BIT; then -> STOP.
REQ-016 Stop bit SHALL be sampled at t0 + CLKS_PER_BIT/2 + 6*CLKS_PER_BIT; FSM -> IDLE on that same edge.
REQ-017 valid SHALL be asserted for exactly one cycle, in the cycle immediately following the stop-bit sample edge.
REQ-018 parity_err SHALL equal XOR of the four received data bits and the received parity bit; it SHALL update only when valid asserts.
REQ-019 frame_err SHALL equal NOT of the sampled stop bit; it SHALL update only when valid asserts.
REQ-020 data, parity_err and frame_err SHALL hold their values from the last valid pulse until the next valid pulse; data SHALL NOT change visibly mid-frame (shift into an internal register, copy to data on completion).
REQ-021 A frame with frame_err = 1 SHALL still produce valid and its data/parity result.
REQ-022 rx low in the cycle after a stop sample (back-to-back frames) SHALL be accepted as a new start; IDLE needs no minimum dwell.
REQ-023 rx glitches between sample points SHALL have no effect; only the mid-bit samples in REQ-013..016 are used.
REQ-024 busy SHALL rise the cycle after t0 and fall in the cycle valid asserts (or after a false start returns to IDLE).

Reset
REQ-025 While rst is high at a rising edge: state -> IDLE; counters -> 0; data -> 4'b0000; valid, parity_err, frame_err, busy -> 0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no valid pulse; data and flags SHALL read 0 afterwards.
REQ-027 After rst deasserts, the first rx = 0 sample SHALL start a frame per REQ-012; rx held low through reset SHALL count as a start on the first edge after reset.

Verification (CLKS_PER_BIT = 4, 1 bit = 4 clk)
REQ-028 Frame data 4'b1011, parity 1, stop 1 -> one valid pulse 27 cycles after t0, data = 4'b1011, parity_err = 0, frame_err = 0.
REQ-029 Frame data 4'b0110, parity 1 (wrong), stop 1 -> valid, data = 4'b0110, parity_err = 1, frame_err = 0.
REQ-030 Frame data 4'b0001, parity 1, stop 0 -> valid, data = 4'b0001, parity_err = 0, frame_err = 1.
REQ-031 rx low for 1 cycle then high -> no valid, busy high for 2 cycles, FSM back in IDLE, outputs unchanged.
REQ-032 Two back-to-back frames 4'b1111/p0 then 4'b1000/p1 with no idle gap -> two valid pulses 28 cycles apart, data 4'b1111 then 4'b1000, no errors.
REQ-033 rst pulsed during data bit 2 of a frame -> no valid, data = 0, flags = 0; next full frame 4'b0101/p0 received correctly.
